ahb_button_controller: RTL and testbench
========================================

Name: ahb_button_controller

Overview:
- Parametrised AHB-Lite slave that debounces NUM_BUTTONS active-low push buttons.
- Classifies each press as a short or long press and latches per-button event flags.
- Event flags are clear-on-read; a maskable interrupt line is provided.
- Replaces the fixed two-button manager on the peripheral bus so the CPU no longer polls at a fixed rate.

Parameters:
- NUM_BUTTONS, 4, number of button channels (1..32).
- DEB_CYCLES, 900, consecutive stable HCLK cycles required to accept a level change (~25 ms at 36 kHz).
- LONG_CYCLES, 32000, debounced-hold cycles after which a press is classified long; must be > DEB_CYCLES.

Ports:
- HCLK  input  1  system clock; the only clock.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  AHB slave select.
- HADDR  input  32  address; only HADDR[4:2] decoded.
- HTRANS  input  2  transfer type; IDLE (2'b00) ignored.
- HWRITE  input  1  write strobe.
- HSIZE  input  3  ignored (word access only).
- HWDATA  input  32  write data (data phase).
- HREADY  input  1  bus ready.
- Buttons  input  NUM_BUTTONS  raw, asynchronous, active-low button inputs.
- HRDATA  output  32  read data.
- HREADYOUT  output  1  tied to 1; no wait states.
- IRQ  output  1  OR of (SHORT_EVT|LONG_EVT) & IRQ_EN.

Behaviour:
- Reset values:
  - HRDATA=0, IRQ=0.
  - All registers, counters and flags = 0.
  - Debounced level = released (1).
  - Synchroniser flops = 1.
- Input synchronisation: each Buttons bit passes a 2-flop synchroniser (2-cycle latency).
- Per-channel debouncer:
  - Counter resets to 0 whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments.
  - When it reaches DEB_CYCLES-1 on a mismatching cycle, the debounced level toggles and the counter clears.
  - A glitch shorter than DEB_CYCLES therefore never changes the level.
- Per-channel press FSM, states IDLE, HELD, LONG:
  - IDLE -> HELD on debounced falling edge; hold counter cleared.
  - HELD: hold counter increments each cycle.
    - Debounced rising edge before the count reaches LONG_CYCLES: set SHORT_EVT[i], go to IDLE.
    - Count reaches LONG_CYCLES: set LONG_EVT[i] once, go to LONG.
  - LONG -> IDLE on debounced rising edge; no further event.
  - Hold counter width is $clog2(LONG_CYCLES+1) and saturates, never wraps.
- Channels are independent. Simultaneous events on several channels all latch in the same cycle.
- Register map (word offsets):
  - 0x00 SHORT_EVT: RO, clear-on-read.
  - 0x04 LONG_EVT: RO, clear-on-read.
  - 0x08 LEVEL: RO; debounced levels inverted, 1 = pressed.
  - 0x0C IRQ_EN: RW, NUM_BUTTONS bits.
  - 0x10 STATUS: RO, no side effect. Bit0 = any SHORT_EVT, bit1 = any LONG_EVT.
  - Other offsets read 0 and ignore writes.
  - Bits above NUM_BUTTONS read 0.
- AHB timing:
  - The address phase is captured when HSEL & HREADY & HTRANS!=IDLE, storing address and HWRITE.
  - The following cycle is the data phase.
  - HRDATA is combinational from the registered address and is valid throughout the data phase.
  - A write to IRQ_EN takes HWDATA in the data phase and is effective the next cycle.
  - A write to an RO register has no effect.
- Clear-on-read:
  - On the clock edge ending the data phase of a read of SHORT_EVT or LONG_EVT, only the bits returned as 1 are cleared.
  - Update rule: flag_next = (flag & ~(read_clear ? returned : 0)) | set. A new event in the same cycle survives.
  - Back-to-back reads are supported, one per cycle.
- IRQ is registered: it asserts the cycle after a flag sets and deasserts the cycle after clear or mask.
- Reset mid-press:
  - All state returns to reset values; no event is generated.
  - A button still held after reset is accepted as a new press after synchroniser + DEB_CYCLES.

Test Plan:
- Parameters NUM_BUTTONS=4, DEB_CYCLES=4, LONG_CYCLES=20 for all scenarios.
- Bouncy press: Buttons[0] low 3 cycles, high 1, low 10, high 10 -> one SHORT_EVT=0x1; LEVEL bit0 was 1 during the stable low.
- Long press: Buttons[2] low 40 cycles -> LONG_EVT=0x4 asserts once; release gives no SHORT_EVT; read LONG_EVT returns 0x4, re-read returns 0x0.
- Interrupt: write IRQ_EN=0x2, short press on button 1 -> IRQ=1; read SHORT_EVT returns 0x2 and IRQ=0 the cycle after the data phase; a button 3 press gives no IRQ.
- Clear/set collision: button 0 short event latches in the exact read data-phase cycle of SHORT_EVT (value 0x2 returned) -> post-read SHORT_EVT=0x1.
- Simultaneous: buttons 0 and 3 pressed/released together -> SHORT_EVT=0x9; STATUS=0x1; IDLE-HTRANS read of 0x00 does not clear.
- Reset: assert HRESETn=0 during button 1 hold at count 15, then release reset with the button held -> no event until press completes; all registers read 0 immediately after reset.

Source files
------------

// File: rtl/ahb_button_controller.sv
// AHB-Lite slave: debounces active-low buttons, classifies short/long presses, clear-on-read event flags + IRQ.
// Latency: 2-cycle synchroniser + DEB_CYCLES debounce; reads return data in the cycle after the address phase.
// Backpressure: none; HREADYOUT is tied high and every transfer completes without wait states.
module ahb_button_controller #(
    parameter int NUM_BUTTONS = 4,
    parameter int DEB_CYCLES  = 900,
    parameter int LONG_CYCLES = 32000
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HSEL,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [31:0]            HWDATA,
    input  logic                   HREADY,
    input  logic [NUM_BUTTONS-1:0] Buttons,
    output logic [31:0]            HRDATA,
    output logic                   HREADYOUT,
    output logic                   IRQ
);

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} press_st_t;

    logic [NUM_BUTTONS-1:0] short_set, long_set, level_n;
    logic [NUM_BUTTONS-1:0] short_evt, long_evt, irq_en;
    logic                   dp_vld, dp_wr;
    logic [2:0]             dp_addr;
    logic [31:0]            rd_mux;
    logic                   rd_short, rd_long, wr_irq_en;
    logic                   unused_ok;

    assign HREADYOUT = 1'b1;
    assign unused_ok = &{1'b0, HSIZE, HADDR[31:5], HADDR[1:0], HWDATA};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : gen_ch
        logic              sync1, sync2, deb;
        logic [DEB_W-1:0]  deb_cnt;
        logic [HOLD_W-1:0] hold_cnt, hold_inc;
        press_st_t         st;
        logic              deb_chg, fall, rise;

        // The debounced edge is acted on in the same cycle the level toggles.
        assign deb_chg  = (sync2 != deb) && (deb_cnt == DEB_W'(DEB_CYCLES - 1));
        assign fall     = deb_chg && deb;
        assign rise     = deb_chg && !deb;
        assign hold_inc = (hold_cnt == HOLD_W'(LONG_CYCLES)) ? hold_cnt : hold_cnt + HOLD_W'(1);

        assign short_set[i] = (st == ST_HELD) && rise;
        assign long_set[i]  = (st == ST_HELD) && !rise && (hold_inc == HOLD_W'(LONG_CYCLES));
        assign level_n[i]   = ~deb;

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                sync1    <= 1'b1;
                sync2    <= 1'b1;
                deb      <= 1'b1;
                deb_cnt  <= '0;
                hold_cnt <= '0;
                st       <= ST_IDLE;
            end else begin
                sync1 <= Buttons[i];
                sync2 <= sync1;
                if (deb_chg) begin
                    deb     <= ~deb;
                    deb_cnt <= '0;
                end else if (sync2 == deb) begin
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
                unique case (st)
                    ST_IDLE: begin
                        hold_cnt <= '0;
                        if (fall) st <= ST_HELD;
                    end
                    ST_HELD: begin
                        if (rise) begin
                            st <= ST_IDLE;
                        end else begin
                            hold_cnt <= hold_inc;
                            if (hold_inc == HOLD_W'(LONG_CYCLES)) st <= ST_LONG;
                        end
                    end
                    ST_LONG: begin
                        if (rise) st <= ST_IDLE;
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

    assign rd_short  = dp_vld && !dp_wr && (dp_addr == 3'd0);
    assign rd_long   = dp_vld && !dp_wr && (dp_addr == 3'd1);
    assign wr_irq_en = dp_vld && dp_wr && (dp_addr == 3'd3);

    always_comb begin
        rd_mux = '0;
        unique case (dp_addr)
            3'd0:    rd_mux = 32'(short_evt);
            3'd1:    rd_mux = 32'(long_evt);
            3'd2:    rd_mux = 32'(level_n);
            3'd3:    rd_mux = 32'(irq_en);
            3'd4:    rd_mux = {30'b0, |long_evt, |short_evt};
            default: rd_mux = '0;
        endcase
        HRDATA = (dp_vld && !dp_wr) ? rd_mux : '0;
    end

    // Only the bits actually returned by the read are cleared; a set in the same cycle wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_vld    <= 1'b0;
            dp_wr     <= 1'b0;
            dp_addr   <= '0;
            short_evt <= '0;
            long_evt  <= '0;
            irq_en    <= '0;
            IRQ       <= 1'b0;
        end else begin
            dp_vld    <= HSEL && HREADY && (HTRANS != 2'b00);
            dp_wr     <= HWRITE;
            dp_addr   <= HADDR[4:2];
            short_evt <= (short_evt & ~(rd_short ? short_evt : '0)) | short_set;
            long_evt  <= (long_evt & ~(rd_long ? long_evt : '0)) | long_set;
            if (wr_irq_en) irq_en <= HWDATA[NUM_BUTTONS-1:0];
            IRQ       <= |((short_evt | long_evt) & irq_en);
        end
    end

endmodule

// File: tb/tb_ahb_button_controller.sv
// Bench for ahb_button_controller: register vector tables plus scripted button sequences, read data checked via a scoreboard queue.
module tb_ahb_button_controller;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [3:0]  Buttons;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       nm_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        wr_vecs[9];
    logic [31:0] rst_addrs[5];

    ahb_button_controller #(
        .NUM_BUTTONS(4),
        .DEB_CYCLES (4),
        .LONG_CYCLES(20)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .Buttons  (Buttons),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .IRQ      (IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        tick();
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        logic [31:0] ev;
        string       en;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        ev = exp_q.pop_front();
        en = nm_q.pop_front();
        check(en, HRDATA, ev);
        tick();
    endtask

    task automatic press(input logic [3:0] mask, input int lo, input int hi);
        Buttons = Buttons & ~mask;
        repeat (lo) tick();
        Buttons = Buttons | mask;
        repeat (hi) tick();
    endtask

    initial begin
        wr_vecs[0] = '{32'h0C, 32'h0000_000F, 32'h0000_000F, "irq_en_all"};
        wr_vecs[1] = '{32'h0C, 32'hFFFF_FFFF, 32'h0000_000F, "irq_en_upper_bits"};
        wr_vecs[2] = '{32'h0C, 32'h0000_0005, 32'h0000_0005, "irq_en_0x5"};
        wr_vecs[3] = '{32'h00, 32'h0000_000F, 32'h0000_0000, "short_ro"};
        wr_vecs[4] = '{32'h04, 32'h0000_000F, 32'h0000_0000, "long_ro"};
        wr_vecs[5] = '{32'h08, 32'h0000_000F, 32'h0000_0000, "level_ro"};
        wr_vecs[6] = '{32'h10, 32'h0000_0003, 32'h0000_0000, "status_ro"};
        wr_vecs[7] = '{32'h14, 32'h0000_000F, 32'h0000_0000, "unmapped_0x14"};
        wr_vecs[8] = '{32'h0C, 32'h0000_0000, 32'h0000_0000, "irq_en_clear"};
        rst_addrs  = '{32'h08, 32'h00, 32'h04, 32'h0C, 32'h10};

        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = '0; HREADY = 1'b1; Buttons = 4'hF;
        repeat (3) tick();
        check("reset_hrdata", HRDATA, 32'h0);
        check("reset_irq", {31'b0, IRQ}, 32'h0);
        check("hreadyout", {31'b0, HREADYOUT}, 32'h1);
        HRESETn = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            bus_write(wr_vecs[i].addr, wr_vecs[i].wdata);
            bus_read(wr_vecs[i].addr, wr_vecs[i].exp, wr_vecs[i].name);
        end

        // Bouncy press on button 0
        press(4'h1, 3, 1);
        Buttons[0] = 1'b0;
        repeat (7) tick();
        bus_read(32'h08, 32'h1, "bouncy_level");
        tick();
        Buttons[0] = 1'b1;
        repeat (10) tick();
        bus_read(32'h00, 32'h1, "bouncy_short");
        bus_read(32'h04, 32'h0, "bouncy_no_long");
        bus_read(32'h00, 32'h0, "bouncy_short_cleared");

        // Long press on button 2
        Buttons[2] = 1'b0;
        repeat (30) tick();
        bus_read(32'h10, 32'h2, "long_status");
        bus_read(32'h04, 32'h4, "long_evt");
        repeat (4) tick();
        bus_read(32'h04, 32'h0, "long_evt_once");
        Buttons[2] = 1'b1;
        repeat (10) tick();
        bus_read(32'h00, 32'h0, "long_no_short");
        bus_read(32'h04, 32'h0, "long_after_release");

        // Interrupt masking
        bus_write(32'h0C, 32'h2);
        press(4'h2, 10, 10);
        check("irq_set", {31'b0, IRQ}, 32'h1);
        bus_read(32'h00, 32'h2, "irq_short_read");
        tick();
        check("irq_cleared", {31'b0, IRQ}, 32'h0);
        press(4'h8, 10, 10);
        check("irq_masked", {31'b0, IRQ}, 32'h0);
        bus_read(32'h00, 32'h8, "masked_short");
        bus_write(32'h0C, 32'h0);

        // Clear/set collision: bit 0 latches on the edge ending the read's data phase
        press(4'h2, 10, 10);
        Buttons[0] = 1'b0;
        repeat (10) tick();
        Buttons[0] = 1'b1;
        repeat (4) tick();
        bus_read(32'h00, 32'h2, "collide_read");
        bus_read(32'h00, 32'h1, "collide_survivor");

        // Simultaneous press, IDLE transfer must not clear
        press(4'h9, 10, 10);
        bus_read(32'h10, 32'h1, "simul_status");
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
        tick();
        HSEL = 1'b0;
        tick();
        bus_read(32'h00, 32'h9, "simul_short");
        bus_read(32'h00, 32'h0, "simul_cleared");

        // Reset in the middle of a hold
        bus_write(32'h0C, 32'hF);
        press(4'h8, 10, 10);
        check("pre_reset_irq", {31'b0, IRQ}, 32'h1);
        Buttons[1] = 1'b0;
        repeat (20) tick();
        HRESETn = 1'b0;
        tick();
        check("midreset_irq", {31'b0, IRQ}, 32'h0);
        tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_read(rst_addrs[i], 32'h0, $sformatf("post_reset_0x%02h", rst_addrs[i]));
        end
        bus_read(32'h08, 32'h2, "post_reset_level");
        Buttons[1] = 1'b1;
        repeat (10) tick();
        bus_read(32'h00, 32'h2, "post_reset_short");
        bus_read(32'h04, 32'h0, "post_reset_no_long");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
